axis_packet_source: RTL and testbench

AXIS_PACKET_SOURCE -- requirements
Module: axis_packet_source

---
 rtl/axis_packet_source.sv | 128 ++++++++++++
 tb/tb_axis_packet_source.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_source.sv
`default_nettype none
// ============================================================================
// Module      : axis_packet_source
// Description : AXI-Stream packet generator. Emits pkt_len beats of Galois
//               LFSR data per start request. The optional per-packet maximum
//               tracker is enabled by defining SRC_MAX_TRACK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_source #(
    parameter int STREAM_WIDTH = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic                    start,
    input  logic [15:0]             pkt_len,
    input  logic [31:0]             seed,
    input  logic                    TREADY,
    output logic [STREAM_WIDTH-1:0] TDATA,
    output logic                    TVALID,
    output logic                    TLAST,
    output logic                    busy,
    output logic                    done,
    output logic [15:0]             exp_max,
    output logic                    exp_max_valid
);

    localparam logic [31:0] C_POLY = 32'h8020_0003;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_count;
    logic [31:0] r_lfsr;
    logic        r_done;

    logic        w_sending;
    logic        w_hs;
    logic        w_last;
    logic        w_accept;
    logic [31:0] w_lfsr_step;

    assign w_sending   = (r_state == SEND);
    assign w_hs        = w_sending && TREADY;
    assign w_last      = w_sending && (r_count == 16'd1);
    assign w_accept    = (r_state == IDLE) && start && (pkt_len != 16'd0);
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ C_POLY) : (r_lfsr >> 1);

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_state_next = SEND;
            SEND: if (w_hs && w_last) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Counter and LFSR only move on a handshake, so stalled beats hold steady.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_count <= 16'd0;
            r_lfsr  <= 32'h0000_0001;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_hs && w_last;
            if (w_accept) begin
                r_count <= pkt_len;
                r_lfsr  <= (seed == 32'd0) ? 32'h0000_0001 : seed;
            end else if (w_hs) begin
                r_count <= r_count - 16'd1;
                r_lfsr  <= w_lfsr_step;
            end
        end
    end

    always_comb begin
        TDATA = '0;
        if (w_sending) begin
            TDATA[15:0] = r_lfsr[15:0];
        end
    end

    assign TVALID = w_sending;
    assign TLAST  = w_last;
    assign busy   = w_sending;
    assign done   = r_done;

`ifdef SRC_MAX_TRACK_EN
    logic        r_first;
    logic [15:0] r_exp_max;

    // r_first marks that the next handshake is the packet's opening beat.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_first   <= 1'b0;
            r_exp_max <= 16'd0;
        end else begin
            if (w_accept) begin
                r_first <= 1'b1;
            end else if (w_hs) begin
                r_first <= 1'b0;
                if (r_first || (r_lfsr[15:0] > r_exp_max)) begin
                    r_exp_max <= r_lfsr[15:0];
                end
            end
        end
    end

    assign exp_max       = r_exp_max;
    assign exp_max_valid = r_done;
`else
    assign exp_max       = 16'd0;
    assign exp_max_valid = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_axis_packet_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_packet_source
// Description : Scoreboard bench for axis_packet_source.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_packet_source;

    localparam int W = 32;
    localparam logic [31:0] C_POLY = 32'h8020_0003;

    logic          ACLK = 1'b0;
    logic          ARESET = 1'b1;
    logic          start = 1'b0;
    logic [15:0]   pkt_len = 16'd0;
    logic [31:0]   seed = 32'd0;
    logic          TREADY = 1'b0;
    logic [W-1:0]  TDATA;
    logic          TVALID;
    logic          TLAST;
    logic          busy;
    logic          done;
    logic [15:0]   exp_max;
    logic          exp_max_valid;

    int            total = 0;
    int            bad = 0;
    logic [W:0]    sb[$];
    logic          exp_done = 1'b0;

    axis_packet_source #(.STREAM_WIDTH(W)) dut (
        .ACLK(ACLK), .ARESET(ARESET), .start(start), .pkt_len(pkt_len),
        .seed(seed), .TREADY(TREADY), .TDATA(TDATA), .TVALID(TVALID),
        .TLAST(TLAST), .busy(busy), .done(done), .exp_max(exp_max),
        .exp_max_valid(exp_max_valid)
    );

    always #5 ACLK = ~ACLK;

    // Expected beats of one packet from an independent LFSR model.
    task automatic push_pkt(input logic [31:0] sd, input int len, output logic [15:0] mx);
        logic [31:0] l;
        logic [15:0] d;
        logic        lst;
        l  = (sd == 32'd0) ? 32'd1 : sd;
        mx = 16'd0;
        for (int i = 0; i < len; i++) begin
            d   = l[15:0];
            lst = (i == len - 1);
            if (i == 0 || d > mx) mx = d;
            sb.push_back({lst, 16'h0000, d});
            l = l[0] ? ((l >> 1) ^ C_POLY) : (l >> 1);
        end
    endtask

    task automatic send_start(input logic [31:0] sd, input logic [15:0] len);
        @(posedge ACLK); #1;
        start = 1'b1; seed = sd; pkt_len = len;
        @(posedge ACLK); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, input string nm);
        logic got;
        got = 1'b0;
        for (int i = 0; i < maxc && !got; i++) begin
            @(negedge ACLK);
            if (done === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout: done=0 required=1 within %0d cycles", nm, maxc);
        end
    endtask

    task automatic monitor();
        logic [W:0] e;
        forever begin
            @(negedge ACLK);
            if (ARESET) begin
                exp_done = 1'b0;
            end else begin
                total++;
                if (done !== exp_done) begin
                    bad++;
                    $display("FAIL done_pulse: got=%b required=%b t=%0t", done, exp_done, $time);
                end
`ifdef SRC_MAX_TRACK_EN
                total++;
                if (exp_max_valid !== exp_done) begin
                    bad++;
                    $display("FAIL exp_max_valid: got=%b required=%b", exp_max_valid, exp_done);
                end
`endif
                if (TVALID === 1'b1 && TREADY === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL extra_beat: got data=%h last=%b required=none", TDATA, TLAST);
                    end else begin
                        e = sb.pop_front();
                        if ({TLAST, TDATA} !== e) begin
                            bad++;
                            $display("FAIL beat: got last=%b data=%h required last=%b data=%h",
                                     TLAST, TDATA, e[W], e[W-1:0]);
                        end
                    end
                end
                exp_done = (TVALID === 1'b1) && (TREADY === 1'b1) && (TLAST === 1'b1);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge ACLK);
        #1;
        total++;
        if ({TVALID, TLAST, busy, done, exp_max_valid} !== 5'b0 || TDATA !== '0 || exp_max !== 16'd0) begin
            bad++;
            $display("FAIL reset_state: got v=%b l=%b b=%b d=%b data=%h max=%h required all zero",
                     TVALID, TLAST, busy, done, TDATA, exp_max);
        end
        ARESET = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] mx;
        TREADY = 1'b1;
        push_pkt(32'd1, 4, mx);
        send_start(32'd1, 16'd4);
        total++;
        if (TVALID !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_latency: got v=%b b=%b required 1 1", TVALID, busy);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            total++;
            if (TVALID !== 1'b1 || TLAST !== (i == 3)) begin
                bad++;
                $display("FAIL basic_beat%0d: got v=%b l=%b required v=1 l=%b", i, TVALID, TLAST, (i == 3));
            end
        end
        @(negedge ACLK);
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || TVALID !== 1'b0) begin
            bad++;
            $display("FAIL basic_end: got d=%b b=%b v=%b required 1 0 0", done, busy, TVALID);
        end
`ifdef SRC_MAX_TRACK_EN
        total++;
        if (exp_max !== mx) begin
            bad++;
            $display("FAIL basic_max: got=%h required=%h", exp_max, mx);
        end
        @(negedge ACLK);
        total++;
        if (exp_max !== mx) begin
            bad++;
            $display("FAIL max_hold: got=%h required=%h", exp_max, mx);
        end
`else
        total++;
        if (exp_max !== 16'd0 || exp_max_valid !== 1'b0) begin
            bad++;
            $display("FAIL max_tied: got=%h/%b required 0/0", exp_max, exp_max_valid);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [15:0] mx;
        TREADY = 1'b1;
        push_pkt(32'd1, 4, mx);
        send_start(32'd1, 16'd4);
        @(posedge ACLK); #1;
        TREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            total++;
            if (TVALID !== 1'b1 || TDATA !== 32'h3 || TLAST !== 1'b0) begin
                bad++;
                $display("FAIL stall%0d: got v=%b data=%h l=%b required v=1 data=3 l=0", i, TVALID, TDATA, TLAST);
            end
        end
        @(posedge ACLK); #1;
        TREADY = 1'b1;
        wait_done(10, "backpressure");
    endtask

    task automatic test_single();
        logic [15:0] mx;
        TREADY = 1'b1;
        push_pkt(32'd0, 1, mx);
        send_start(32'd0, 16'd1);
        total++;
        if (TLAST !== 1'b1 || TDATA !== 32'h1) begin
            bad++;
            $display("FAIL single: got l=%b data=%h required l=1 data=1", TLAST, TDATA);
        end
        wait_done(4, "single");
    endtask

    task automatic test_ignore();
        logic [15:0] mx;
        TREADY = 1'b1;
        send_start(32'd1, 16'd0);
        @(negedge ACLK);
        total++;
        if (busy !== 1'b0 || TVALID !== 1'b0) begin
            bad++;
            $display("FAIL zero_len: got b=%b v=%b required 0 0", busy, TVALID);
        end
        push_pkt(32'd5, 3, mx);
        send_start(32'd5, 16'd3);
        send_start(32'd9, 16'd5);
        wait_done(10, "ignore");
        repeat (3) @(negedge ACLK);
        total++;
        if (busy !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL ignore_idle: got b=%b pending=%0d required 0 0", busy, sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] mx;
        TREADY = 1'b1;
        push_pkt(32'd7, 8, mx);
        send_start(32'd7, 16'd8);
        @(posedge ACLK);
        @(posedge ACLK); #2;
        ARESET = 1'b1;
        #1;
        total++;
        if (TVALID !== 1'b0 || TLAST !== 1'b0 || busy !== 1'b0 || TDATA !== '0 || exp_max !== 16'd0) begin
            bad++;
            $display("FAIL reset_mid: got v=%b l=%b b=%b data=%h max=%h required zeros",
                     TVALID, TLAST, busy, TDATA, exp_max);
        end
        #1;
        ARESET = 1'b0;
        sb.delete();
        push_pkt(32'd1, 2, mx);
        send_start(32'd1, 16'd2);
        wait_done(6, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [15:0] mx;
        TREADY = 1'b1;
        push_pkt(32'd1, 2, mx);
        push_pkt(32'd1, 2, mx);
        @(posedge ACLK); #1;
        start = 1'b1; seed = 32'd1; pkt_len = 16'd2;
        wait_done(8, "b2b_first");
        total++;
        if (TVALID !== 1'b0) begin
            bad++;
            $display("FAIL b2b_gap: got v=%b required 0", TVALID);
        end
        @(posedge ACLK); #1;
        start = 1'b0;
        total++;
        if (TVALID !== 1'b1 || TDATA !== 32'h1) begin
            bad++;
            $display("FAIL b2b_restart: got v=%b data=%h required v=1 data=1", TVALID, TDATA);
        end
        wait_done(6, "b2b_second");
    endtask

    task automatic test_random_ready();
        logic [15:0] mx;
        logic        got;
        TREADY = 1'b1;
        push_pkt(32'h1234_ABCD, 20, mx);
        send_start(32'h1234_ABCD, 16'd20);
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(posedge ACLK); #1;
            TREADY = 1'($urandom_range(0, 1));
            @(negedge ACLK);
            if (done === 1'b1) got = 1'b1;
        end
        TREADY = 1'b1;
        total++;
        if (!got) begin
            bad++;
            $display("FAIL random_timeout: done=0 required=1");
        end
`ifdef SRC_MAX_TRACK_EN
        total++;
        if (exp_max !== mx) begin
            bad++;
            $display("FAIL random_max: got=%h required=%h", exp_max, mx);
        end
`endif
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_backpressure();
        test_single();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random_ready();
        repeat (3) @(negedge ACLK);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL leftover_beats: got=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
